// File: rtl/layer0_in_packer_pkg.sv
// layer0_in_packer_pkg: shared layer-0 widths, quantizer code width and default thresholds.
package layer0_in_packer_pkg;
  localparam int Q_BITS      = 2;
  localparam int Q_T0        = -4096;
  localparam int Q_T1        = 0;
  localparam int Q_T2        = 4096;
  localparam int NEURON_IN_W = 16;
  localparam int NEURON_FEAT = 8;
endpackage

// File: rtl/layer0_in_packer_feat_quant.sv
// feat_quant: maps one signed sample to a 2-bit code by counting thresholds it reaches.
module feat_quant import layer0_in_packer_pkg::*; #(
  parameter int IN_W = NEURON_IN_W,
  parameter logic signed [IN_W-1:0] T0 = IN_W'(Q_T0),
  parameter logic signed [IN_W-1:0] T1 = IN_W'(Q_T1),
  parameter logic signed [IN_W-1:0] T2 = IN_W'(Q_T2)
) (
  input  logic signed [IN_W-1:0] x,
  output logic [Q_BITS-1:0]      code
);
  assign code = Q_BITS'(x >= T0) + Q_BITS'(x >= T1) + Q_BITS'(x >= T2);
endmodule

// File: rtl/layer0_in_packer.sv
// layer0_in_packer: quantizes a stream of readout features and packs each shot into one vector
// for the layer-0 neurons, with a single-entry output register and s_first resynchronisation.
module layer0_in_packer import layer0_in_packer_pkg::*; #(
  parameter int NUM_FEAT = NEURON_FEAT,
  parameter int IN_W = NEURON_IN_W,
  parameter logic signed [IN_W-1:0] T0 = IN_W'(Q_T0),
  parameter logic signed [IN_W-1:0] T1 = IN_W'(Q_T1),
  parameter logic signed [IN_W-1:0] T2 = IN_W'(Q_T2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [IN_W-1:0]     s_data,
  input  logic                       s_first,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_FEAT*Q_BITS-1:0] m_data,
  output logic                       resync_err,
  output logic [15:0]                frame_cnt
);
  localparam int IW = NUM_FEAT > 1 ? $clog2(NUM_FEAT) : 1;
  localparam int VW = NUM_FEAT * Q_BITS;
  logic [IW-1:0] idx_q, idx_d, idx_eff;
  logic [VW-1:0] asm_q, asm_d, asm_new, m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, resync_err_q, resync_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [Q_BITS-1:0] code;
  logic accept, emit, resync, last;
  feat_quant #(.IN_W(IN_W), .T0(T0), .T1(T1), .T2(T2)) u_quant (.x(s_data), .code(code));
  assign s_ready = !m_valid_q || m_ready;
  // A mid-shot s_first restarts assembly with this sample as feature 0.
  always_comb begin
    accept = s_valid && s_ready;
    emit = m_valid_q && m_ready;
    resync = accept && s_first && idx_q != '0;
    idx_eff = resync ? '0 : idx_q;
    last = idx_eff == IW'(NUM_FEAT - 1);
    asm_new = resync ? '0 : asm_q;
    asm_new[Q_BITS*idx_eff +: Q_BITS] = code;
    idx_d = accept ? (last ? '0 : idx_eff + 1'b1) : idx_q;
    asm_d = accept ? (last ? '0 : asm_new) : asm_q;
    m_data_d = accept && last ? asm_new : m_data_q;
    m_valid_d = (accept && last) || (m_valid_q && !m_ready);
    resync_err_d = resync;
    frame_cnt_d = frame_cnt_q + 16'(emit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
      resync_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
      resync_err_q <= resync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign resync_err = resync_err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_layer0_in_packer.sv
// tb_layer0_in_packer: randomized and directed stimulus checked every cycle against a queue-based shot model.
module tb_layer0_in_packer;
  logic clk = 0, rst_n = 0, s_valid = 0, s_first = 0, m_ready = 0;
  logic signed [15:0] s_data = 0;
  logic s_ready, m_valid, resync_err;
  logic [15:0] m_data, frame_cnt;
  logic rst1_n = 0, s_ready1, m_valid1, resync_err1;
  logic [1:0] m_data1;
  logic [15:0] frame_cnt1;
  logic signed [15:0] s_data1 = 16'sd5000;
  int vectors = 0, errors = 0, cyc = 0;
  int em_edges[$];
  bit wrap_done = 0;
  int feats[$];
  bit mv = 0, er = 0;
  int md = 0, fc = 0;

  layer0_in_packer dut (.clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_first(s_first), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .resync_err(resync_err),
    .frame_cnt(frame_cnt));
  layer0_in_packer #(.NUM_FEAT(1)) dut1 (.clk(clk), .rst_n(rst1_n), .s_valid(1'b1), .s_ready(s_ready1),
    .s_data(s_data1), .s_first(1'b0), .m_valid(m_valid1), .m_ready(1'b1), .m_data(m_data1),
    .resync_err(resync_err1), .frame_cnt(frame_cnt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int q(input int x);
    return int'(x >= -4096) + int'(x >= 0) + int'(x >= 4096);
  endfunction

  function automatic int rnd_x();
    int t[3] = '{-4096, 0, 4096};
    int d = int'($urandom_range(4));
    if ($urandom_range(1) == 1) return int'($signed(16'($urandom)));
    return t[$urandom_range(2)] + d - 2;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Shot model: features collect in a queue; a full queue becomes the pending vector.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      feats.delete(); mv = 0; md = 0; fc = 0; er = 0;
    end else begin
      bit acc, em, nv;
      acc = s_valid && (!mv || m_ready);
      em = mv && m_ready;
      er = 0; nv = 0;
      if (em) fc = (fc + 1) % 65536;
      if (acc) begin
        if (s_first && feats.size() != 0) begin
          feats.delete(); er = 1;
        end
        feats.push_back(q(int'(s_data)));
        if (feats.size() == 8) begin
          md = 0;
          foreach (feats[k]) md += feats[k] << (2 * k);
          feats.delete(); nv = 1;
        end
      end
      mv = nv ? 1'b1 : (em ? 1'b0 : mv);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("s_ready", s_ready, !mv || m_ready);
    chk("m_valid", m_valid, mv);
    chk("m_data", m_data, md);
    chk("resync_err", resync_err, er);
    chk("frame_cnt", frame_cnt, fc);
    if (rst_n && m_valid && m_ready) em_edges.push_back(cyc + 1);
  end

  task automatic send(input int x, input bit f);
    int n = 0;
    s_valid = 1; s_data = 16'(x); s_first = f;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #2;
    s_valid = 0; s_first = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int n = 0;
    repeat (3) @(posedge clk);
    #2 rst1_n = 1;
    while (n < 65536) begin
      @(negedge clk);
      if (m_valid1) begin
        if (n == 65535) chk("wrap_pre", frame_cnt1, 65535);
        n++;
      end
    end
    @(negedge clk);
    chk("wrap_zero", frame_cnt1, 0);
    chk("nf1_data", m_data1, 3);
    wrap_done = 1;
  end

  initial begin
    int samp[8] = '{-5000, -100, 0, 4096, 100, -4096, 5000, -1};
    int c0, w;
    logic [15:0] hold;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    idle(3);
    rst_n = 1; m_ready = 1;
    idle(1);
    foreach (samp[i]) send(samp[i], i == 0);
    @(negedge clk);
    chk("vec_valid", m_valid, 1);
    chk("vec_data", m_data, 16'h76E4);
    @(negedge clk);
    chk("vec_frame", frame_cnt, 1);
    // Back-pressure: vector must sit unchanged and block input.
    idle(1); m_ready = 0;
    for (int i = 0; i < 8; i++) send(rnd_x(), i == 0);
    @(negedge clk);
    chk("bp_s_ready", s_ready, 0);
    hold = m_data;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", m_data, hold);
      chk("bp_valid", m_valid, 1);
    end
    @(posedge clk); #2 m_ready = 1;
    for (int i = 0; i < 8; i++) send(rnd_x(), i == 0);
    idle(2);
    // Resync: fourth sample restarts the shot.
    for (int i = 0; i < 3; i++) send(rnd_x(), i == 0);
    send(5000, 1);
    @(negedge clk);
    chk("resync_pulse", resync_err, 1);
    @(negedge clk);
    chk("resync_clear", resync_err, 0);
    idle(0);
    for (int i = 0; i < 7; i++) send(-5000, 0);
    @(negedge clk);
    chk("resync_f0", m_data, 16'h0003);
    idle(3);
    // Continuous stream: vectors every 8 cycles, no bubbles.
    em_edges.delete();
    c0 = cyc;
    for (int i = 0; i < 32; i++) send(rnd_x(), i % 8 == 0);
    idle(3);
    chk("stream_cnt", em_edges.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("stream_edge", em_edges.size() > i ? em_edges[i] - c0 : -1, 9 + 8 * i);
    for (int i = 0; i < 1500; i++) begin
      s_valid = $urandom_range(3) != 0;
      s_first = $urandom_range(11) == 0;
      s_data = 16'(rnd_x());
      m_ready = $urandom_range(2) != 0;
      @(posedge clk); #2;
    end
    s_valid = 0; s_first = 0; m_ready = 1;
    idle(3);
    // Reset mid-shot drops the partial vector.
    for (int i = 0; i < 5; i++) send(rnd_x(), i == 0);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_frame", frame_cnt, 0);
    idle(2);
    rst_n = 1;
    idle(1);
    chk("post_rst_ready", s_ready, 1);
    for (int i = 0; i < 8; i++) send(samp[i], 0);
    @(negedge clk);
    chk("post_rst_vec", m_data, 16'h76E4);
    w = 0;
    while (!wrap_done && w < 80000) begin @(posedge clk); w++; end
    if (!wrap_done) chk("wrap_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
